// File: rtl/cdc_pulse_sync_mc.sv
// Multi-channel toggle-handshake pulse synchroniser from clka to clkb.
// Each channel reports busy/done/drop in clka and reproduces one pulse per accepted request in clkb.
`timescale 1ns/100ps
module cdc_pulse_sync_mc #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          rst,
    input  logic          clka,
    input  logic          clkb,
    input  logic [CH-1:0] pulse_a,
    input  logic [CH-1:0] clr_drop_a,
    output logic [CH-1:0] busy_a,
    output logic [CH-1:0] done_a,
    output logic [CH-1:0] drop_a,
    output logic [CH-1:0] pulse_b
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t                 state_r;
        state_t                 state_nx_s;
        logic                   tog_r;
        logic                   tog_nx_s;
        logic                   busy_r;
        logic                   done_r;
        logic                   done_nx_s;
        logic                   drop_r;
        logic                   drop_nx_s;
        logic [SYNC_STAGES-1:0] bsync_r;
        logic                   hist_r;
        logic [SYNC_STAGES-1:0] async_r;
        logic                   ack_tog_s;

        assign ack_tog_s = async_r[SYNC_STAGES-1];

        // Source handshake: next state, toggle, done strobe and sticky drop flag.
        always_comb begin
            state_nx_s = state_r;
            tog_nx_s   = tog_r;
            done_nx_s  = 1'b0;
            drop_nx_s  = drop_r;
            case (state_r)
                IDLE: begin
                    if (pulse_a[i]) begin
                        tog_nx_s   = ~tog_r;
                        state_nx_s = WAIT_ACK;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (ack_tog_s == tog_r) begin
                        state_nx_s = IDLE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = WAIT_ACK;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
            // A pulse during WAIT_ACK is lost even on the ack edge, so set beats clear.
            if ((state_r == WAIT_ACK) && pulse_a[i]) begin
                drop_nx_s = 1'b1;
            end else if (clr_drop_a[i]) begin
                drop_nx_s = 1'b0;
            end else begin
                drop_nx_s = drop_r;
            end
        end

        // Source-domain state and output registers.
        always_ff @(posedge clka or negedge rst) begin
            if (!rst) begin
                state_r <= IDLE;
                tog_r   <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
                drop_r  <= 1'b0;
            end else begin
                state_r <= state_nx_s;
                tog_r   <= tog_nx_s;
                busy_r  <= (state_nx_s == WAIT_ACK);
                done_r  <= done_nx_s;
                drop_r  <= drop_nx_s;
            end
        end

        // Destination-domain synchroniser chain and edge-detect history flop.
        always_ff @(posedge clkb or negedge rst) begin
            if (!rst) begin
                bsync_r <= '0;
                hist_r  <= 1'b0;
            end else begin
                bsync_r <= {bsync_r[SYNC_STAGES-2:0], tog_r};
                hist_r  <= bsync_r[SYNC_STAGES-1];
            end
        end

        // Acknowledge path: the destination's last sync flop returned into clka.
        always_ff @(posedge clka or negedge rst) begin
            if (!rst) begin
                async_r <= '0;
            end else begin
                async_r <= {async_r[SYNC_STAGES-2:0], bsync_r[SYNC_STAGES-1]};
            end
        end

        // Only one of the two flops changes per clkb edge, so the XOR cannot glitch.
        assign pulse_b[i] = bsync_r[SYNC_STAGES-1] ^ hist_r;
        assign busy_a[i]  = busy_r;
        assign done_a[i]  = done_r;
        assign drop_a[i]  = drop_r;
    end

endmodule

// File: tb/tb_cdc_pulse_sync_mc.sv
// Directed bench for cdc_pulse_sync_mc: latency, fast/slow ratios, drops, reset abort, short random mix.
`timescale 1ns/100ps
module tb_cdc_pulse_sync_mc;

    localparam int CH = 4;

    logic          rst;
    logic          clka;
    logic          clkb;
    logic [CH-1:0] pulse_a;
    logic [CH-1:0] clr_drop_a;
    logic [CH-1:0] busy_a;
    logic [CH-1:0] done_a;
    logic [CH-1:0] drop_a;
    logic [CH-1:0] pulse_b;

    realtime ha = 10.0;
    realtime hb = 3.0;

    int total = 0;
    int bad   = 0;

    int pb_cnt[CH]  = '{default: 0};
    int dn_cnt[CH]  = '{default: 0};
    int iss_cnt[CH] = '{default: 0};
    int drp_cnt[CH] = '{default: 0};
    int pb0[CH];
    int dn0[CH];
    int is0[CH];
    int dr0[CH];

    int ha_tab[4] = '{3, 15, 5, 13};
    int hb_tab[4] = '{15, 3, 11, 4};

    cdc_pulse_sync_mc #(.CH(CH), .SYNC_STAGES(2)) dut (
        .rst        (rst),
        .clka       (clka),
        .clkb       (clkb),
        .pulse_a    (pulse_a),
        .clr_drop_a (clr_drop_a),
        .busy_a     (busy_a),
        .done_a     (done_a),
        .drop_a     (drop_a),
        .pulse_b    (pulse_b)
    );

    initial begin
        clka = 1'b0;
        forever #(ha) clka = ~clka;
    end

    // clkb keeps a half-ns offset so its edges never coincide with clka's.
    initial begin
        clkb = 1'b0;
        #0.5;
        forever #(hb) clkb = ~clkb;
    end

    always @(posedge clkb) begin
        for (int i = 0; i < CH; i++) if (pulse_b[i]) pb_cnt[i]++;
    end

    always @(posedge clka) begin
        for (int i = 0; i < CH; i++) begin
            if (done_a[i]) dn_cnt[i]++;
            if (pulse_a[i]) begin
                iss_cnt[i]++;
                if (busy_a[i]) drp_cnt[i]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        pb0 = pb_cnt;
        dn0 = dn_cnt;
        is0 = iss_cnt;
        dr0 = drp_cnt;
    endtask

    task automatic pulse(input logic [CH-1:0] m);
        @(negedge clka);
        pulse_a = m;
        @(negedge clka);
        pulse_a = '0;
    endtask

    task automatic clr(input logic [CH-1:0] m);
        @(negedge clka);
        clr_drop_a = m;
        @(negedge clka);
        clr_drop_a = '0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clka);
    endtask

    initial begin
        int first_idx;
        int n;
        int d_pb, d_is, d_dr, d_dn;

        rst        = 1'b0;
        pulse_a    = '0;
        clr_drop_a = '0;
        repeat (3) @(negedge clka);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        chk("rst_pulse_b", 32'(pulse_b), 32'd0);
        rst = 1'b1;
        settle(3);

        // Single ch0 pulse, clka 20 ns / clkb 6 ns.
        snap();
        @(negedge clka);
        pulse_a = 4'b0001;
        @(posedge clka);
        fork
            begin
                @(negedge clka);
                pulse_a = '0;
            end
        join_none
        #1;
        chk("busy_set", 32'(busy_a), 32'h1);
        first_idx = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clkb);
            #1;
            if (pulse_b[0] && first_idx == 0) first_idx = k;
        end
        chk("pb0_latency", 32'(first_idx >= 2 && first_idx <= 3), 32'd1);
        chk("busy_hold", 32'(busy_a), 32'h1);
        settle(8);
        chk("pb0_count", 32'(pb_cnt[0] - pb0[0]), 32'd1);
        chk("done0_count", 32'(dn_cnt[0] - dn0[0]), 32'd1);
        chk("busy_clear", 32'(busy_a), 32'd0);
        chk("others_quiet", 32'((pb_cnt[1] - pb0[1]) + (pb_cnt[2] - pb0[2]) + (pb_cnt[3] - pb0[3])), 32'd0);

        // Fast to slow: ten ch2 pulses 200 ns apart.
        ha = 3.0;
        hb = 10.0;
        settle(20);
        snap();
        for (int k = 0; k < 10; k++) begin
            pulse(4'b0100);
            #194;
        end
        #200;
        chk("f2s_pb2", 32'(pb_cnt[2] - pb0[2]), 32'd10);
        chk("f2s_done2", 32'(dn_cnt[2] - dn0[2]), 32'd10);
        chk("f2s_drop", 32'(drop_a), 32'd0);

        // Back-to-back ch1 pulses: one transfer, one drop.
        ha = 10.0;
        hb = 3.0;
        settle(5);
        snap();
        @(negedge clka);
        pulse_a = 4'b0010;
        @(negedge clka);
        @(negedge clka);
        pulse_a = '0;
        settle(10);
        chk("b2b_pb1", 32'(pb_cnt[1] - pb0[1]), 32'd1);
        chk("b2b_drop", 32'(drop_a), 32'h2);
        clr(4'b0010);
        chk("clr_drop", 32'(drop_a), 32'd0);

        // Set and clear in the same cycle keeps the flag.
        @(negedge clka);
        pulse_a = 4'b0010;
        @(negedge clka);
        clr_drop_a = 4'b0010;
        @(negedge clka);
        pulse_a    = '0;
        clr_drop_a = '0;
        settle(10);
        chk("set_over_clr", 32'(drop_a), 32'h2);
        clr(4'b0010);

        // Pulse held through the ack edge: the ack wins, no second transfer.
        snap();
        @(negedge clka);
        pulse_a = 4'b0010;
        n = 0;
        @(negedge clka);
        while (!done_a[1] && n < 40) begin
            @(negedge clka);
            n++;
        end
        pulse_a = '0;
        chk("ackwin_done_seen", 32'(n < 40), 32'd1);
        settle(10);
        chk("ackwin_pb1", 32'(pb_cnt[1] - pb0[1]), 32'd1);
        chk("ackwin_done1", 32'(dn_cnt[1] - dn0[1]), 32'd1);
        chk("ackwin_drop", 32'(drop_a), 32'h2);
        clr(4'b0010);

        // All four channels in one cycle.
        snap();
        pulse(4'b1111);
        settle(10);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("all_pb_ch%0d", i), 32'(pb_cnt[i] - pb0[i]), 32'd1);
            chk($sformatf("all_done_ch%0d", i), 32'(dn_cnt[i] - dn0[i]), 32'd1);
        end

        // Reset one clkb cycle after a ch3 accept aborts the transfer.
        snap();
        @(negedge clka);
        pulse_a = 4'b1000;
        @(posedge clka);
        @(posedge clkb);
        #1;
        rst     = 1'b0;
        pulse_a = '0;
        #1;
        chk("rst_mid_outs", 32'({busy_a, done_a, drop_a, pulse_b}), 32'd0);
        repeat (3) @(negedge clka);
        rst = 1'b1;
        settle(10);
        chk("rst_abort_pb3", 32'(pb_cnt[3] - pb0[3]), 32'd0);
        pulse(4'b1000);
        settle(10);
        chk("rst_next_pb3", 32'(pb_cnt[3] - pb0[3]), 32'd1);

        // Random traffic over several clock ratios: transfers plus drops equal requests.
        for (int c = 0; c < 4; c++) begin
            ha = real'(ha_tab[c]);
            hb = real'(hb_tab[c]);
            settle(10);
            snap();
            repeat (150) begin
                @(negedge clka);
                pulse_a = 4'($urandom & $urandom);
            end
            @(negedge clka);
            pulse_a = '0;
            #2000;
            for (int i = 0; i < CH; i++) begin
                d_pb = pb_cnt[i] - pb0[i];
                d_dn = dn_cnt[i] - dn0[i];
                d_is = iss_cnt[i] - is0[i];
                d_dr = drp_cnt[i] - dr0[i];
                chk($sformatf("rnd%0d_bal_ch%0d", c, i), 32'(d_pb + d_dr), 32'(d_is));
                chk($sformatf("rnd%0d_done_ch%0d", c, i), 32'(d_dn), 32'(d_pb));
                chk($sformatf("rnd%0d_flag_ch%0d", c, i), 32'(drop_a[i]), 32'(d_dr > 0));
            end
            chk($sformatf("rnd%0d_idle", c), 32'(busy_a), 32'd0);
            clr(4'b1111);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_pulse_sync_mc.md
CDC_PULSE_SYNC_MC -- requirements
Module: cdc_pulse_sync_mc

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent pulse channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop count per crossing (2..4).
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low, applied to both clock domains.
REQ-004 The block SHALL have port clka, input, 1 bit: source-domain clock, any frequency ratio to clkb.
REQ-005 The block SHALL have port clkb, input, 1 bit: destination-domain clock.
REQ-006 The block SHALL have port pulse_a, input, CH bits: per-channel single-cycle request pulses, clka domain.
REQ-007 The block SHALL have port clr_drop_a, input, CH bits: per-channel clear of the sticky drop flag, clka domain.
REQ-008 The block SHALL have port busy_a, output, CH bits: channel in flight, new pulse not accepted.
REQ-009 The block SHALL have port done_a, output, CH bits: one-clka-cycle acknowledge when the round trip completes.
REQ-010 The block SHALL have port drop_a, output, CH bits: sticky flag, a pulse arrived while busy.
REQ-011 The block SHALL have port pulse_b, output, CH bits: one-clkb-cycle reproduced pulse, clkb domain.

Function
REQ-012 Each channel SHALL be an independent toggle-handshake synchroniser; channels share no state.
REQ-013 Source FSM per channel SHALL have two states: IDLE (busy_a=0) and WAIT_ACK (busy_a=1).
REQ-014 In IDLE, at a clka edge with pulse_a[i]=1: tog_a[i] inverts, state goes to WAIT_ACK, busy_a[i]=1 from that edge.
REQ-015 tog_a[i] SHALL pass through SYNC_STAGES clkb flops, then one history flop; pulse_b[i] = last sync flop XOR history flop, both registered, no combinational input path.
REQ-016 pulse_b[i] SHALL be high for exactly one clkb cycle per accepted pulse, SYNC_STAGES to SYNC_STAGES+1 clkb edges after tog_a[i] changes.
REQ-017 The last clkb sync flop value SHALL be returned through SYNC_STAGES clka flops as ack_tog[i].
REQ-018 In WAIT_ACK, at the clka edge where ack_tog[i]==tog_a[i], state SHALL return to IDLE, busy_a[i]=0, and done_a[i]=1 for that one cycle.
REQ-019 pulse_a[i]=1 in WAIT_ACK SHALL be ignored for transfer and SHALL set drop_a[i]=1 at that edge, including the edge where ack completes (ack wins, the pulse is dropped).
REQ-020 drop_a[i] SHALL be cleared by clr_drop_a[i]=1; simultaneous set and clear SHALL leave drop_a[i]=1.
REQ-021 pulse_a[i] held high for several clka cycles SHALL transfer once, with the remaining cycles counting as drops.
REQ-022 The block SHALL work for clka faster or slower than clkb; no pulse is lost except as flagged by drop_a.
REQ-023 No combinational logic SHALL sit between a domain's flop and the first synchroniser flop of the other domain.

Reset
REQ-024 While rst=0: tog_a, state, sync chains, history flops, busy_a, done_a, drop_a and pulse_b SHALL all be 0, independent of either clock.
REQ-025 Reset mid-transfer SHALL abort the transfer with no pulse_b after release; the first pulse after release SHALL transfer normally.
REQ-026 Deassertion SHALL be treated as synchronous per domain by the integrator; the block requires no extra reset sequencing.

Verification
REQ-027 CH=4, SYNC_STAGES=2, clka 20 ns, clkb 6 ns: pulse_a=4'b0001 for one cycle -> pulse_b[0] high exactly one clkb cycle within 3 clkb edges; busy_a[0] high until done_a[0]; other channels stay 0.
REQ-028 Same clocks, clka 6 ns, clkb 20 ns (fast to slow): single pulses 200 ns apart on ch2, 10 of them -> exactly 10 pulse_b[2] pulses, drop_a=0.
REQ-029 Ch1 pulses on two consecutive clka cycles -> one pulse_b[1], drop_a[1]=1; clr_drop_a[1] pulse -> drop_a[1]=0.
REQ-030 pulse_a=4'b1111 in one cycle -> four pulse_b pulses and four done_a pulses, each channel exactly once.
REQ-031 rst=0 asserted 1 clkb cycle after a ch3 accept -> all outputs 0; after release, no pulse_b[3]; the next ch3 pulse transfers once.
REQ-032 A randomized run (10 000 pulses, random clock ratio 0.2-5) SHALL satisfy: pulse_b count + drop count = pulse_a count per channel.
